// File: rtl/hdmi_eth_pkg.sv
// hdmi_eth_pkg: shared frame/packet defaults, address width and scheduler state encoding
package hdmi_eth_pkg;
    localparam int DEF_PIXELS_PER_FRAME = 57600;
    localparam int DEF_PIXELS_PER_PKT   = 320;
    localparam int DEF_IPG_CYCLES       = 1000;
    localparam int ADDR_W               = 16;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_DONE, ST_GAP} state_t;
endpackage

// File: rtl/start_frame_sync.sv
// start_frame_sync: 2-flop synchronizer for start_frame plus rising-edge detect on the second stage
//   clk125MHz, rstb (async active-low) | start_frame: async pulse in | start_evt: one-cycle event out
module start_frame_sync (
    input  logic clk125MHz,
    input  logic rstb,
    input  logic start_frame,
    output logic start_evt
);
    logic s1, s2, s2_d;
    always_ff @(posedge clk125MHz or negedge rstb) begin
        if (!rstb) {s1, s2, s2_d} <= '0;
        else       {s1, s2, s2_d} <= {start_frame, s1, s2};
    end
    assign start_evt = s2 & ~s2_d;
endmodule

// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: double-buffered frame capture banks, splits each frame into paced Ethernet packet requests
//   clk125MHz, rstb (async active-low) | enable, start_frame: frame acceptance
//   pkt_req/pkt_ack/pkt_done + pkt_base_addr/pkt_len/pkt_seq/frame_id: TX engine handshake
//   wr_bank, busy, frame_done, frames_dropped: status
module frame_tx_scheduler import hdmi_eth_pkg::*; #(
    parameter int PIXELS_PER_FRAME = DEF_PIXELS_PER_FRAME,
    parameter int PIXELS_PER_PKT   = DEF_PIXELS_PER_PKT,
    parameter int IPG_CYCLES       = DEF_IPG_CYCLES
) (
    input  logic          clk125MHz,
    input  logic          rstb,
    input  logic          enable,
    input  logic          start_frame,
    output logic          pkt_req,
    input  logic          pkt_ack,
    input  logic          pkt_done,
    output logic [16:0]   pkt_base_addr,
    output logic [15:0]   pkt_len,
    output logic [15:0]   pkt_seq,
    output logic [7:0]    frame_id,
    output logic          wr_bank,
    output logic          busy,
    output logic          frame_done,
    output logic [15:0]   frames_dropped
);
    localparam logic [15:0]       LAST_SEQ = 16'(PIXELS_PER_FRAME / PIXELS_PER_PKT - 1);
    localparam int                GW       = $clog2(IPG_CYCLES + 2);
    localparam logic [GW-1:0]     GAP_LOAD = GW'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);
    localparam logic [ADDR_W-1:0] PKT_STEP = ADDR_W'(PIXELS_PER_PKT);

    state_t              state, state_n;
    logic                start_evt, accept, launch, advance, last_done, primed, rd_bank;
    logic [ADDR_W-1:0]   offset;
    logic [GW-1:0]       gap_cnt;

    start_frame_sync u_sync (
        .clk125MHz  (clk125MHz),
        .rstb       (rstb),
        .start_frame(start_frame),
        .start_evt  (start_evt)
    );

    assign accept        = start_evt && state == ST_IDLE && enable;
    assign pkt_req       = state == ST_REQ;
    assign busy          = state != ST_IDLE;
    assign pkt_base_addr = {rd_bank, offset};

    always_ff @(posedge clk125MHz or negedge rstb) begin
        if (!rstb) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        launch    = 1'b0;
        advance   = 1'b0;
        last_done = 1'b0;
        case (state)
            ST_IDLE: begin
                // until one frame has been captured the read bank holds nothing worth sending
                if (accept && primed) begin
                    state_n = ST_REQ;
                    launch  = 1'b1;
                end
            end
            ST_REQ: state_n = pkt_ack ? ST_WAIT_DONE : ST_REQ;
            ST_WAIT_DONE: begin
                if (pkt_done) begin
                    if (pkt_seq == LAST_SEQ) begin
                        state_n   = ST_IDLE;
                        last_done = 1'b1;
                    end else if (IPG_CYCLES == 0) begin
                        state_n = ST_REQ;
                        advance = 1'b1;
                    end else begin
                        state_n = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_n = ST_REQ;
                    advance = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk125MHz or negedge rstb) begin
        if (!rstb) begin
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b0;
            primed         <= 1'b0;
            frame_done     <= 1'b0;
            frames_dropped <= '0;
            pkt_seq        <= '0;
            pkt_len        <= '0;
            offset         <= '0;
            gap_cnt        <= '0;
            frame_id       <= '0;
        end else begin
            frame_done <= last_done;
            if (accept) begin
                wr_bank <= ~wr_bank;
                rd_bank <= wr_bank;
                primed  <= 1'b1;
            end else if (start_evt && frames_dropped != 16'hFFFF) begin
                frames_dropped <= frames_dropped + 16'd1;
            end
            if (launch) begin
                pkt_seq <= '0;
                offset  <= '0;
                pkt_len <= 16'(PIXELS_PER_PKT);
            end
            if (advance) begin
                pkt_seq <= pkt_seq + 16'd1;
                offset  <= offset + PKT_STEP;
            end
            // loaded on the pkt_done that enters GAP so GAP spans exactly IPG_CYCLES cycles
            if (state == ST_WAIT_DONE && pkt_done) gap_cnt <= GAP_LOAD;
            else if (state == ST_GAP)              gap_cnt <= gap_cnt - GW'(1);
            if (last_done) frame_id <= frame_id + 8'd1;
        end
    end
endmodule

// File: tb/tb_frame_tx_scheduler.sv
// tb_frame_tx_scheduler: scoreboard bench for frame_tx_scheduler with a modelled TX engine
module tb_frame_tx_scheduler;
    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic        rstb, enable, main_start, tx_start, start_frame, pkt_ack, pkt_done;
    logic        pkt_req, wr_bank, busy, frame_done;
    logic [16:0] pkt_base_addr;
    logic [15:0] pkt_len, pkt_seq, frames_dropped;
    logic [7:0]  frame_id;
    assign start_frame = main_start | tx_start;

    logic        start2, ack2, done2, req2, wr2, busy2, fd2;
    logic [16:0] addr2;
    logic [15:0] len2, seq2, drop2;
    logic [7:0]  fid2;

    frame_tx_scheduler #(.PIXELS_PER_FRAME(8), .PIXELS_PER_PKT(4), .IPG_CYCLES(3)) u_dut (
        .clk125MHz(clk), .rstb(rstb), .enable(enable), .start_frame(start_frame),
        .pkt_req(pkt_req), .pkt_ack(pkt_ack), .pkt_done(pkt_done),
        .pkt_base_addr(pkt_base_addr), .pkt_len(pkt_len), .pkt_seq(pkt_seq),
        .frame_id(frame_id), .wr_bank(wr_bank), .busy(busy),
        .frame_done(frame_done), .frames_dropped(frames_dropped)
    );

    frame_tx_scheduler #(.PIXELS_PER_FRAME(8), .PIXELS_PER_PKT(4), .IPG_CYCLES(0)) u_ipg0 (
        .clk125MHz(clk), .rstb(rstb), .enable(1'b1), .start_frame(start2),
        .pkt_req(req2), .pkt_ack(ack2), .pkt_done(done2),
        .pkt_base_addr(addr2), .pkt_len(len2), .pkt_seq(seq2),
        .frame_id(fid2), .wr_bank(wr2), .busy(busy2),
        .frame_done(fd2), .frames_dropped(drop2)
    );

    typedef struct packed {
        logic [16:0] addr;
        logic [15:0] len;
        logic [15:0] seq;
        logic [7:0]  fid;
    } pkt_t;

    pkt_t exp_q[$];
    int   checks = 0, errors = 0;
    int   fd_count = 0, req_rises = 0, cyc = 0, t_done = 0;
    logic inject_last = 1'b0, ipg0_finished = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic bank, input logic [7:0] fid);
        for (int s = 0; s < 2; s++) exp_q.push_back({bank, 16'(s * 4), 16'd4, 16'(s), fid});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 main_start = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 main_start = 1'b0;
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 50 && !pkt_ack; i++) @(negedge clk);
        check("ack_seen", pkt_ack, 1);
    endtask

    task automatic wait_frame_done(input int target);
        for (int i = 0; i < 100 && fd_count < target; i++) @(negedge clk);
        check("frame_done_count", fd_count, target);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    // TX engine: ack one cycle after req, pkt_done five cycles after ack
    initial begin
        pkt_ack = 1'b0; pkt_done = 1'b0; tx_start = 1'b0;
        forever begin
            @(negedge clk);
            if (pkt_req && rstb) begin
                @(posedge clk); #1 pkt_ack = 1'b1;
                @(posedge clk); #1 pkt_ack = 1'b0;
                @(posedge clk);
                @(posedge clk); #1 if (inject_last && pkt_seq == 16'd1) tx_start = 1'b1;
                @(posedge clk);
                @(posedge clk); #1 pkt_done = 1'b1;
                @(posedge clk); #1 pkt_done = 1'b0; tx_start = 1'b0;
            end
        end
    end

    // monitor: pops the scoreboard on every accepted request
    initial begin
        pkt_t cur, prev, e;
        logic req_prev;
        req_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            cur = {pkt_base_addr, pkt_len, pkt_seq, frame_id};
            if (frame_done) fd_count++;
            if (pkt_req && req_prev) check("req_stable", cur, prev);
            if (pkt_req && !req_prev) req_rises++;
            if (pkt_req && pkt_ack) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pkt: got seq %0d expected no packet", pkt_seq);
                end else begin
                    e = exp_q.pop_front();
                    check("pkt_addr", pkt_base_addr, e.addr);
                    check("pkt_len", pkt_len, e.len);
                    check("pkt_seq", pkt_seq, e.seq);
                    check("pkt_frame_id", frame_id, e.fid);
                end
            end
            if (pkt_done && pkt_seq == 16'd0) t_done = cyc;
            if (pkt_req && !req_prev && pkt_seq == 16'd1) check("ipg3_gap", cyc - t_done, 4);
            req_prev = pkt_req;
            prev = cur;
        end
    end

    // zero-gap instance: next request must follow pkt_done immediately
    initial begin
        start2 = 1'b0; ack2 = 1'b0; done2 = 1'b0;
        wait (rstb === 1'b1);
        repeat (2) begin
            @(posedge clk); #1 start2 = 1'b1;
            repeat (2) @(posedge clk);
            #1 start2 = 1'b0;
            repeat (3) @(posedge clk);
        end
        for (int i = 0; i < 20 && !req2; i++) @(negedge clk);
        check("ipg0_req0", req2, 1);
        check("ipg0_addr0", addr2, 17'h10000);
        @(posedge clk); #1 ack2 = 1'b1;
        @(posedge clk); #1 ack2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 done2 = 1'b1;
        @(negedge clk); check("ipg0_req_during_done", req2, 0);
        @(posedge clk); #1 done2 = 1'b0;
        @(negedge clk);
        check("ipg0_req_next", req2, 1);
        check("ipg0_seq1", seq2, 1);
        check("ipg0_addr1", addr2, 17'h10004);
        @(posedge clk); #1 ack2 = 1'b1;
        @(posedge clk); #1 ack2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 done2 = 1'b1;
        @(posedge clk); #1 done2 = 1'b0;
        @(negedge clk);
        check("ipg0_frame_done", fd2, 1);
        check("ipg0_frame_id", fid2, 1);
        check("ipg0_busy", busy2, 0);
        ipg0_finished = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        rstb = 1'b0; enable = 1'b1; main_start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pkt_req", pkt_req, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_bank", wr_bank, 0);
        check("rst_fields", {pkt_base_addr, pkt_len, pkt_seq, frame_id}, 0);
        check("rst_dropped", frames_dropped, 0);
        check("rst_frame_done", frame_done, 0);
        @(posedge clk); #1 rstb = 1'b1;

        // first start only primes the banks
        pulse_start();
        settle();
        check("prime_wr_bank", wr_bank, 1);
        check("prime_busy", busy, 0);
        check("prime_no_req", req_rises, 0);

        // second start sends bank 1
        push_frame(1'b1, 8'd0);
        pulse_start();
        @(negedge clk); check("req_latency_early", pkt_req, 0);
        @(negedge clk); check("req_latency", pkt_req, 1);
        wait_frame_done(1);
        settle();
        check("f1_wr_bank", wr_bank, 0);
        check("f1_frame_id", frame_id, 1);
        check("f1_busy", busy, 0);
        check("f1_frame_done_once", fd_count, 1);
        check("f1_dropped", frames_dropped, 0);

        // starts during WAIT_DONE and on the last pkt_done are dropped
        push_frame(1'b0, 8'd1);
        inject_last = 1'b1;
        pulse_start();
        wait_ack();
        pulse_start();
        wait_frame_done(2);
        inject_last = 1'b0;
        settle();
        check("drop_count", frames_dropped, 2);
        check("drop_wr_bank", wr_bank, 1);
        check("drop_frame_id", frame_id, 2);
        check("drop_frame_done_once", fd_count, 2);

        // disabled in IDLE: rejected
        rises = req_rises;
        enable = 1'b0;
        pulse_start();
        settle();
        check("dis_dropped", frames_dropped, 3);
        check("dis_no_req", req_rises, rises);
        check("dis_wr_bank", wr_bank, 1);

        // enable falling mid-frame does not abort it
        enable = 1'b1;
        push_frame(1'b1, 8'd2);
        pulse_start();
        wait_ack();
        enable = 1'b0;
        wait_frame_done(3);
        settle();
        check("midf_frame_id", frame_id, 3);
        check("midf_wr_bank", wr_bank, 0);
        enable = 1'b1;

        for (int i = 0; i < 200 && !ipg0_finished; i++) @(negedge clk);
        check("ipg0_finished", ipg0_finished, 1);

        // reset during the gap after packet 0
        push_frame(1'b0, 8'd3);
        pulse_start();
        for (int i = 0; i < 50 && !pkt_done; i++) @(negedge clk);
        check("gap_done_seen", pkt_done, 1);
        @(posedge clk); #1 rstb = 1'b0;
        #1;
        check("arst_pkt_req", pkt_req, 0);
        check("arst_busy", busy, 0);
        check("arst_wr_bank", wr_bank, 0);
        check("arst_fields", {pkt_base_addr, pkt_len, pkt_seq, frame_id}, 0);
        check("arst_dropped", frames_dropped, 0);
        check("arst_pending", exp_q.size(), 1);
        exp_q.delete();
        repeat (5) @(negedge clk);
        @(posedge clk); #1 rstb = 1'b1;
        settle();
        check("arst_no_frame_done", fd_count, 3);
        pulse_start();
        settle();
        check("reprime_wr_bank", wr_bank, 1);
        check("reprime_busy", busy, 0);
        push_frame(1'b1, 8'd0);
        pulse_start();
        wait_frame_done(4);
        settle();
        check("reprime_frame_id", frame_id, 1);
        check("reprime_wr_bank2", wr_bank, 0);

        // saturation of the drop counter
        enable = 1'b0;
        @(posedge clk); #1 force u_dut.frames_dropped = 16'hFFFE;
        @(posedge clk); #1 release u_dut.frames_dropped;
        @(negedge clk); check("sat_preload", frames_dropped, 16'hFFFE);
        pulse_start();
        settle();
        check("sat_reach", frames_dropped, 16'hFFFF);
        pulse_start();
        settle();
        check("sat_hold", frames_dropped, 16'hFFFF);
        check("sat_wr_bank", wr_bank, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
